// File: rtl/raster_frame_ctrl.sv
// raster_frame_ctrl: frame sequencer for the triangle rasterizer.
// Clears the frame buffer and z-buffer on frame start, then hands triangle jobs to the
// rasterizer one at a time. Each job has a watchdog. The frame-buffer write port is shared
// between the clear engine and the rasterizer. Frame completion is reported with a pulse.
`timescale 1ns/1ps

module raster_frame_ctrl #(
    parameter int unsigned H_RES        = 320,
    parameter int unsigned V_RES        = 240,
    parameter int unsigned ADDR_W       = 17,
    parameter logic [7:0]  Z_FAR        = 8'hFF,
    parameter int unsigned RAST_TIMEOUT = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [7:0]        bg_color,
    input  logic              frame_end,
    input  logic              tri_valid,
    output logic              tri_ready,
    output logic              rast_start,
    output logic              rast_abort,
    input  logic              rast_done,
    input  logic              rast_we,
    input  logic [ADDR_W-1:0] rast_addr,
    input  logic [7:0]        rast_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              zclr_we,
    output logic [ADDR_W-1:0] zclr_addr,
    output logic [7:0]        zclr_din,
    output logic              frame_done,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       tri_count
);

    localparam int unsigned       NPIX      = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int unsigned       WD_W      = $clog2(RAST_TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(RAST_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READY,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [7:0]        bg_lat;
    logic              end_pending;
    logic [WD_W-1:0]   wdog;

    // Frame sequencer: state, counters, sticky status and registered handshake/pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            clr_cnt     <= '0;
            bg_lat      <= '0;
            end_pending <= 1'b0;
            wdog        <= '0;
            tri_ready   <= 1'b0;
            rast_start  <= 1'b0;
            rast_abort  <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tri_count   <= '0;
        end else begin
            rast_start <= 1'b0;
            rast_abort <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        bg_lat      <= bg_color;
                        tri_count   <= '0;
                        timeout_err <= 1'b0;
                        clr_cnt     <= '0;
                        end_pending <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (frame_end) begin
                        end_pending <= 1'b1;
                    end
                    if (clr_cnt == LAST_ADDR) begin
                        tri_ready <= 1'b1;
                        state     <= S_READY;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                S_READY: begin
                    // An offered triangle wins over a pending end; the end is kept for the next READY.
                    if (tri_valid && tri_ready) begin
                        tri_ready  <= 1'b0;
                        rast_start <= 1'b1;
                        state      <= S_START;
                        if (frame_end) begin
                            end_pending <= 1'b1;
                        end
                    end else if (frame_end || end_pending) begin
                        tri_ready  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_START: begin
                    if (frame_end) begin
                        end_pending <= 1'b1;
                    end
                    wdog  <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (frame_end) begin
                        end_pending <= 1'b1;
                    end
                    if (rast_done) begin
                        if (tri_count != '1) begin
                            tri_count <= tri_count + 16'd1;
                        end
                        tri_ready <= 1'b1;
                        state     <= S_READY;
                    end else if (wdog == WD_LAST) begin
                        rast_abort  <= 1'b1;
                        timeout_err <= 1'b1;
                        tri_ready   <= 1'b1;
                        state       <= S_READY;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_DONE: begin
                    end_pending <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    tri_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Write-port arbitration: clear engine in CLEAR, zero-latency rasterizer pass-through in BUSY
    always_comb begin
        fb_we     = 1'b0;
        fb_addr   = '0;
        fb_data   = '0;
        zclr_we   = 1'b0;
        zclr_addr = '0;
        zclr_din  = '0;
        case (state)
            S_CLEAR: begin
                fb_we     = 1'b1;
                fb_addr   = clr_cnt;
                fb_data   = bg_lat;
                zclr_we   = 1'b1;
                zclr_addr = clr_cnt;
                zclr_din  = Z_FAR;
            end
            S_BUSY: begin
                fb_we   = rast_we;
                fb_addr = rast_addr;
                fb_data = rast_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_raster_frame_ctrl.sv
// Testbench for raster_frame_ctrl: randomized frames and triangle jobs, with a scoreboard of
// expected frame/z-buffer writes and control pulses keyed by cycle number.
`timescale 1ns/1ps

module tb_raster_frame_ctrl;

    localparam int unsigned H_RES = 16;
    localparam int unsigned V_RES = 10;
    localparam int unsigned NPIX  = H_RES * V_RES;
    localparam int unsigned AW    = 17;
    localparam int unsigned TMO   = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic [7:0]    bg_color = '0;
    logic          frame_end = 1'b0;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic          rast_start;
    logic          rast_abort;
    logic          rast_done = 1'b0;
    logic          rast_we = 1'b0;
    logic [AW-1:0] rast_addr = '0;
    logic [7:0]    rast_data = '0;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          zclr_we;
    logic [AW-1:0] zclr_addr;
    logic [7:0]    zclr_din;
    logic          frame_done;
    logic          busy;
    logic          timeout_err;
    logic [15:0]   tri_count;

    raster_frame_ctrl #(
        .H_RES(H_RES),
        .V_RES(V_RES),
        .ADDR_W(AW),
        .Z_FAR(8'hFF),
        .RAST_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_start(frame_start), .bg_color(bg_color), .frame_end(frame_end),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .rast_start(rast_start), .rast_abort(rast_abort), .rast_done(rast_done),
        .rast_we(rast_we), .rast_addr(rast_addr), .rast_data(rast_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .zclr_we(zclr_we), .zclr_addr(zclr_addr), .zclr_din(zclr_din),
        .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
        .tri_count(tri_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_fb[$];
    wr_t exp_z[$];
    int  exp_start[$];
    int  exp_abort[$];
    int  exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference-model state of the current frame
    int m_cnt  = 0;
    bit m_terr = 1'b0;
    bit m_endp = 1'b0;
    int m_c0   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: every output event must match the front of its queue at the exact cycle
    always @(negedge clk) begin
        if (rst) begin
            if (exp_fb.size() > 0 && exp_fb[0].cyc == cyc) begin
                wr_t e;
                e = exp_fb.pop_front();
                chk("fb_we", fb_we, 1);
                chk("fb_addr", fb_addr, e.addr);
                chk("fb_data", fb_data, e.data);
            end else if (fb_we) begin
                chk("fb_we_unexpected", fb_we, 0);
            end
            if (exp_z.size() > 0 && exp_z[0].cyc == cyc) begin
                wr_t e;
                e = exp_z.pop_front();
                chk("zclr_we", zclr_we, 1);
                chk("zclr_addr", zclr_addr, e.addr);
                chk("zclr_din", zclr_din, e.data);
            end else if (zclr_we) begin
                chk("zclr_we_unexpected", zclr_we, 0);
            end
            if (exp_start.size() > 0 && exp_start[0] == cyc) begin
                void'(exp_start.pop_front());
                chk("rast_start", rast_start, 1);
            end else if (rast_start) begin
                chk("rast_start_unexpected", rast_start, 0);
            end
            if (exp_abort.size() > 0 && exp_abort[0] == cyc) begin
                void'(exp_abort.pop_front());
                chk("rast_abort", rast_abort, 1);
            end else if (rast_abort) begin
                chk("rast_abort_unexpected", rast_abort, 0);
            end
            if (exp_done.size() > 0 && exp_done[0] == cyc) begin
                void'(exp_done.pop_front());
                chk("frame_done", frame_done, 1);
            end else if (frame_done) begin
                chk("frame_done_unexpected", frame_done, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse frame_start and predict the whole clear sweep
    task automatic begin_frame(input logic [7:0] bg);
        frame_start = 1'b1;
        bg_color    = bg;
        m_c0        = cyc;
        for (int unsigned i = 0; i < NPIX; i++) begin
            exp_fb.push_back('{cyc: m_c0 + 1 + int'(i), addr: i, data: bg});
            exp_z.push_back('{cyc: m_c0 + 1 + int'(i), addr: i, data: 8'hFF});
        end
        m_cnt  = 0;
        m_terr = 1'b0;
        m_endp = 1'b0;
        tick();
        frame_start = 1'b0;
        bg_color    = 8'($urandom_range(0, 255));
        chk("busy_clear", busy, 1);
        chk("timeout_err_clear", timeout_err, 0);
        chk("tri_count_clear", tri_count, 0);
    endtask

    // Run out the clear while offering ignored stimulus, stopping on the first READY cycle
    task automatic finish_clear();
        while (cyc < m_c0 + 1 + int'(NPIX)) begin
            if (cyc == m_c0 + 4) begin
                chk("tri_ready_clear", tri_ready, 0);
                tri_valid   = 1'b1;
                frame_start = 1'b1;
                rast_done   = 1'b1;
                rast_we     = 1'b1;
                rast_addr   = AW'($urandom_range(0, NPIX - 1));
                rast_data   = 8'($urandom_range(0, 255));
            end else begin
                tri_valid   = 1'b0;
                frame_start = 1'b0;
                rast_done   = 1'b0;
                rast_we     = 1'b0;
            end
            tick();
        end
        tri_valid = 1'b0;
        frame_start = 1'b0;
        rast_done = 1'b0;
        rast_we = 1'b0;
        chk("tri_ready_after_clear", tri_ready, 1);
    endtask

    // One triangle job; d = cycles from rast_start to rast_done, 0 = never done
    task automatic run_tri(input int d, input bit fe_v, input bit fe_b, input bit fs_b);
        int a;
        int lim;
        chk("tri_ready_pre", tri_ready, 1);
        a = cyc;
        tri_valid = 1'b1;
        frame_end = fe_v;
        exp_start.push_back(a + 1);
        rast_we   = 1'b1;
        rast_addr = AW'($urandom_range(0, NPIX - 1));
        rast_data = 8'($urandom_range(0, 255));
        if (fe_v) m_endp = 1'b1;
        tick();
        tri_valid = 1'b0;
        frame_end = 1'b0;
        rast_done = 1'b1;
        rast_we   = 1'($urandom_range(0, 1));
        chk("tri_ready_start", tri_ready, 0);
        tick();
        rast_done = 1'b0;
        lim = (d > 0) ? a + 1 + d : a + 1 + int'(TMO);
        while (cyc <= lim) begin
            rast_we   = 1'($urandom_range(0, 1));
            rast_addr = AW'($urandom_range(0, NPIX - 1));
            rast_data = 8'($urandom_range(0, 255));
            if (rast_we) exp_fb.push_back('{cyc: cyc, addr: rast_addr, data: rast_data});
            rast_done   = (d > 0) && (cyc == lim);
            frame_end   = fe_b && (cyc == a + 3);
            frame_start = fs_b && (cyc == a + 3);
            tick();
        end
        rast_we = 1'b0;
        rast_done = 1'b0;
        frame_end = 1'b0;
        frame_start = 1'b0;
        if (fe_b) m_endp = 1'b1;
        if (d > 0) begin
            if (m_cnt < 16'hFFFF) m_cnt++;
        end else begin
            m_terr = 1'b1;
            exp_abort.push_back(cyc);
        end
        chk("tri_ready_post", tri_ready, 1);
        chk("tri_count", tri_count, m_cnt);
        chk("timeout_err", timeout_err, m_terr);
        if (m_endp) begin
            exp_done.push_back(cyc + 1);
            tick();
            tick();
            chk("busy_idle", busy, 0);
            chk("tri_ready_idle", tri_ready, 0);
            m_endp = 1'b0;
        end
    endtask

    task automatic end_frame();
        chk("tri_ready_end", tri_ready, 1);
        frame_end = 1'b1;
        exp_done.push_back(cyc + 1);
        tick();
        frame_end = 1'b0;
        tick();
        chk("busy_after_end", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tri_ready"}, tri_ready, 0);
        chk({tag, "_rast_start"}, rast_start, 0);
        chk({tag, "_rast_abort"}, rast_abort, 0);
        chk({tag, "_fb_we"}, fb_we, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_zclr_we"}, zclr_we, 0);
        chk({tag, "_zclr_din"}, zclr_din, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_tri_count"}, tri_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // Reset in the middle of a clear
        begin_frame(8'($urandom_range(0, 255)));
        repeat (20) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("reset_mid_clear");
        exp_fb.delete();
        exp_z.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Frame with fixed background, fixed-latency job, random jobs, end during BUSY
        begin_frame(8'h3C);
        finish_clear();
        run_tri(50, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_tri($urandom_range(3, 60), 1'b0, 1'b0, 1'b0);
        end
        run_tri($urandom_range(3, 60), 1'b0, 1'b1, 1'b1);

        // frame_end in IDLE is dropped; watchdog timeout frame
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        begin_frame(8'($urandom_range(0, 255)));
        finish_clear();
        run_tri(0, 1'b0, 1'b0, 1'b0);
        run_tri($urandom_range(3, 60), 1'b0, 1'b0, 1'b0);
        end_frame();

        // timeout_err cleared by new frame; triangle and frame_end together
        begin_frame(8'($urandom_range(0, 255)));
        finish_clear();
        run_tri($urandom_range(3, 60), 1'b1, 1'b0, 1'b0);
        chk("tri_count_final", tri_count, 1);

        repeat (5) tick();
        chk("leftover_fb", exp_fb.size(), 0);
        chk("leftover_z", exp_z.size(), 0);
        chk("leftover_start", exp_start.size(), 0);
        chk("leftover_abort", exp_abort.size(), 0);
        chk("leftover_done", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
